enc_7x1_scan: RTL and testbench
===============================

# enc_7x1_scan

Sequential 7-to-1 request encoder: the return path of the 7-output active-low demux that drives the irrigation zones. Seven active-low request lines (zone sensors/buttons) are synchronised, debounced and latched as pending events. One event at a time is presented as a 3-bit zone code on the same encoding the demux consumes (code k+1 selects line k, 000 selects none), held until acknowledged. A mandatory idle gap separates consecutive grants, so a downstream demux never switches directly from one zone to another.

## Interface
- DEB_W, 4, width of each debounce counter
- DEB_CYCLES, 8, consecutive identical samples needed to change debounced state; legal range 1..2^DEB_W-1
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- In_n  in  7  raw asynchronous request lines, active low, bit k = zone k
- S  out  3  zone code: k+1 while granting line k, 000 otherwise
- valid  out  1  high while S holds a granted code
- ack  in  1  consumer accepts the current code; sampled only while valid=1
- pending  out  7  latched, not-yet-granted events, bit k = zone k
- overrun  out  1  one-cycle pulse: new event on a line whose pending bit is already set

## Operation
- Per line: 2-flop synchroniser, then debounce counter. Counter resets to 0 whenever synced sample equals current debounced state; otherwise increments; at DEB_CYCLES the debounced state flips and the counter clears.
- Event = debounced transition released→asserted (high→low). Release transitions generate nothing.
- Event sets pending[k]. If pending[k] already set: stays set, overrun pulses.
- FSM states:
  - IDLE: S=000, valid=0. If pending≠0, select line, go GRANT.
  - GRANT: S=sel+1, valid=1. On ack: clear pending[sel], go GAP. Without ack: hold S/valid stable indefinitely.
  - GAP: S=000, valid=0 for exactly one cycle, then IDLE.
- Selection: see Configuration. Selection is frozen while in GRANT; new events never change S mid-grant.
- Same-cycle event on sel and ack clearing pending[sel]: event wins, pending[sel] stays 1, no overrun.
- ack outside GRANT is ignored.
- Reset (any state, including mid-GRANT): S=000, valid=0, pending=0, overrun=0, FSM=IDLE, synchronisers and debounced states = released (1), counters=0, round-robin pointer=0. Lines held low through reset produce an event after the normal debounce latency.

## Timing
- Edge 0 = first clk edge sampling In_n[k] low. Debounced low registers at edge DEB_CYCLES+1. pending[k] is set at edge DEB_CYCLES+2. With FSM in IDLE and no other pending line, valid=1/S=k+1 from edge DEB_CYCLES+3.
- Glitches shorter than DEB_CYCLES samples produce no event.
- ack sampled at edge t in GRANT → valid=0, S=000 after t; pending bit cleared at t; earliest next valid after edge t+2 (GAP then IDLE→GRANT).
- Max throughput: one grant per 3 cycles with ack held high.
- overrun registered: high for the single cycle after the duplicate event edge.

## Configuration
- ENC7_ROUND_ROBIN_EN defined: round-robin selection. Pointer p (0..6) is the highest-priority line; search p, p+1, …, wrapping 6→0. On each ack, p ← sel+1 (6 wraps to 0).
- Not defined: fixed priority, lowest index wins (line 0 highest). No pointer register; lines may starve under continuous load.

## Test plan
- DEB_CYCLES=8, In_n[2] low from edge 0, held → pending=0000100 at edge 10, valid=1 and S=011 from edge 11; ack at edge 15 → S=000 and pending=0 after edge 15.
- 5-cycle low pulse on In_n[4] (DEB_CYCLES=8) → no pending bit, valid never rises.
- In_n[0], In_n[3], In_n[6] events simultaneous, ack held high → with ENC7_ROUND_ROBIN_EN: S sequence 001, 000, 100, 000, 111, each code one cycle, S=000 between; without macro: same order (0,3,6); then line 0 re-fires during grant of 3 → round-robin grants 6 before 0, fixed grants 0 before 6.
- Line 5 released and re-asserted (debounced) while pending[5]=1 and not granted → overrun pulses one cycle, only one grant of S=110.
- reset asserted mid-GRANT with S=010 → after next edge S=000, valid=0, pending=0; reset released with In_n[1] still low → S=010 re-presented DEB_CYCLES+3 edges after release.

Source files
------------

// File: rtl/enc_7x1_scan_if.sv
// enc_7x1_scan_if: request/grant bus of the 7-to-1 request encoder.
// master = encoder side (drives the zone code), slave = sensors plus consumer.
// Handshake: the code on S is meaningful only while valid=1. S and valid stay
// stable until the consumer raises ack in a cycle where valid=1; ack is ignored
// while valid=0. After an accepted code, valid stays low for at least two cycles.
interface enc_7x1_scan_if;
    logic [6:0] In_n;
    logic [2:0] S;
    logic       valid;
    logic       ack;
    logic [6:0] pending;
    logic       overrun;

    modport master (
        input  In_n,
        input  ack,
        output S,
        output valid,
        output pending,
        output overrun
    );

    modport slave (
        output In_n,
        output ack,
        input  S,
        input  valid,
        input  pending,
        input  overrun
    );
endinterface

// File: rtl/enc_7x1_scan.sv
// enc_7x1_scan: synchronise, debounce and latch seven active-low request lines,
// then present one pending zone at a time as a 3-bit code (k+1 for line k).
// Optional macro ENC7_ROUND_ROBIN_EN selects round-robin arbitration; when it is
// undefined, arbitration is fixed priority with line 0 highest.
// o_state exposes the grant FSM state (0 idle, 1 grant, 2 gap).
module enc_7x1_scan #(
    parameter int DEB_W      = 4,
    parameter int DEB_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    enc_7x1_scan_if.master        bus,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [6:0]       r_sync1;
    logic [6:0]       r_sync2;
    logic [6:0]       r_deb;
    logic [DEB_W-1:0] r_cnt [7];
    logic [6:0]       r_evt;
    logic [6:0]       r_pending;
    logic             r_overrun;
    state_t           r_state;
    logic [2:0]       r_sel;
    logic [2:0]       r_s;
    logic             r_valid;
    logic [6:0]       w_clr;
    logic [2:0]       w_sel;
`ifdef ENC7_ROUND_ROBIN_EN
    logic [2:0]       r_ptr;
    logic [3:0]       w_idx;
    logic             w_found;
`endif

    // Two-flop synchroniser per line; released (1) out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 7'h7f;
            r_sync2 <= 7'h7f;
        end else begin
            r_sync1 <= bus.In_n;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: count consecutive samples differing from the debounced state,
    // flip after DEB_CYCLES of them; register a one-cycle event on high->low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb <= 7'h7f;
            r_evt <= 7'h00;
            for (int k = 0; k < 7; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 7; k++) begin
                r_evt[k] <= 1'b0;
                if (r_sync2[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == DEB_LAST) begin
                    r_deb[k] <= ~r_deb[k];
                    r_cnt[k] <= '0;
                    r_evt[k] <= r_deb[k];
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Pending bit of the granted line is cleared when its ack is accepted.
    always_comb begin
        w_clr = 7'h00;
        if (r_state == ST_GRANT && bus.ack) begin
            w_clr[r_sel] = 1'b1;
        end
    end

    // Latch events; a new event wins over a same-cycle clear, and an event on an
    // already pending (not being cleared) line is reported as overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 7'h00;
            r_overrun <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | r_evt;
            r_overrun <= |(r_evt & r_pending & ~w_clr);
        end
    end

`ifdef ENC7_ROUND_ROBIN_EN
    // Round-robin pick: first pending line at or after the pointer, wrapping.
    always_comb begin
        w_sel   = 3'd0;
        w_found = 1'b0;
        w_idx   = 4'd0;
        for (int i = 0; i < 7; i++) begin
            w_idx = 4'(r_ptr) + 4'(i);
            if (w_idx > 4'd6) begin
                w_idx = w_idx - 4'd7;
            end
            if (!w_found && r_pending[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[2:0];
            end
        end
    end
`else
    // Fixed priority pick: lowest pending index wins.
    always_comb begin
        w_sel = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = 3'(i);
            end
        end
    end
`endif

    // Grant FSM with registered code/valid; selection is frozen during GRANT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= 3'd0;
            r_s     <= 3'd0;
            r_valid <= 1'b0;
`ifdef ENC7_ROUND_ROBIN_EN
            r_ptr   <= 3'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|r_pending) begin
                        r_sel   <= w_sel;
                        r_s     <= w_sel + 3'd1;
                        r_valid <= 1'b1;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (bus.ack) begin
                        r_s     <= 3'd0;
                        r_valid <= 1'b0;
                        r_state <= ST_GAP;
`ifdef ENC7_ROUND_ROBIN_EN
                        r_ptr   <= (r_sel == 3'd6) ? 3'd0 : r_sel + 3'd1;
`endif
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_s     <= 3'd0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.S       = r_s;
    assign bus.valid   = r_valid;
    assign bus.pending = r_pending;
    assign bus.overrun = r_overrun;
    assign o_state     = r_state;

endmodule

// File: tb/tb_enc_7x1_scan.sv
// tb_enc_7x1_scan: directed scenarios plus random request/ack traffic against
// a per-cycle behavioural model of enc_7x1_scan (DEB_CYCLES = 8).
module tb_enc_7x1_scan;

    localparam int DEB = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    enc_7x1_scan_if bus();
    logic [1:0] dbg_state;

    enc_7x1_scan #(
        .DEB_W      (4),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each line: a two-sample delay, then the debounced level flips once the
    // last DEB delayed samples all disagree with it. Grants: idle -> grant
    // (held until ack) -> one gap cycle -> idle.
    logic [6:0]     m_d1, m_d2, m_deb, m_evt, m_pend;
    logic [DEB-1:0] m_hist [7];
    logic           m_ovr;
    int             m_phase;  // 0 idle, 1 grant, 2 gap
    int             m_sel;
    int             m_ptr;
    bit             m_started = 1'b0;

    function automatic int pick(input logic [6:0] p);
`ifdef ENC7_ROUND_ROBIN_EN
        for (int i = 0; i < 7; i++) begin
            if (p[(m_ptr + i) % 7]) return (m_ptr + i) % 7;
        end
`else
        for (int i = 0; i < 7; i++) begin
            if (p[i]) return i;
        end
`endif
        return 0;
    endfunction

    always @(posedge clk) begin
        logic [6:0] clr, n_pend, n_evt, n_deb;
        logic       n_ovr;
        if (reset) begin
            m_started = 1'b1;
            m_d1 = 7'h7f; m_d2 = 7'h7f; m_deb = 7'h7f;
            m_evt = 7'h00; m_pend = 7'h00; m_ovr = 1'b0;
            for (int k = 0; k < 7; k++) m_hist[k] = '1;
            m_phase = 0; m_sel = 0; m_ptr = 0;
        end else if (m_started) begin
            clr    = (m_phase == 1 && bus.ack) ? (7'b1 << m_sel) : 7'h00;
            n_ovr  = |(m_evt & m_pend & ~clr);
            n_pend = (m_pend & ~clr) | m_evt;
            n_deb  = m_deb;
            n_evt  = 7'h00;
            for (int k = 0; k < 7; k++) begin
                m_hist[k] = {m_hist[k][DEB-2:0], m_d2[k]};
                if (m_hist[k] == {DEB{~m_deb[k]}}) begin
                    n_deb[k] = ~m_deb[k];
                    n_evt[k] = m_deb[k];
                end
            end
            case (m_phase)
                0: if (m_pend != 0) begin m_sel = pick(m_pend); m_phase = 1; end
                1: if (bus.ack) begin m_phase = 2; m_ptr = (m_sel + 1) % 7; end
                default: m_phase = 0;
            endcase
            m_pend = n_pend; m_ovr = n_ovr; m_evt = n_evt; m_deb = n_deb;
            m_d2 = m_d1; m_d1 = bus.In_n;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [2:0] grant_q[$];
    logic [2:0] exp_q[$];
    int  ovr_count = 0;
    int  run_len   = 0;
    int  max_run   = 0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (m_started) begin
            check("S",       32'(bus.S),       32'((m_phase == 1) ? m_sel + 1 : 0));
            check("valid",   32'(bus.valid),   32'(m_phase == 1));
            check("pending", 32'(bus.pending), 32'(m_pend));
            check("overrun", 32'(bus.overrun), 32'(m_ovr));
            if (bus.valid && !prev_valid) grant_q.push_back(bus.S);
            if (bus.overrun) ovr_count++;
            run_len = bus.valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            prev_valid = bus.valid;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_grants(input string tag);
        check({tag, "_count"}, 32'(grant_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < grant_q.size(); i++) begin
            check(tag, 32'(grant_q[i]), 32'(exp_q[i]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        bus.In_n = 7'h7f;
        bus.ack = 1'b0;
        cycles(3);
        check("rst_S", 32'(bus.S), 0);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_pending", 32'(bus.pending), 0);
        check("rst_overrun", 32'(bus.overrun), 0);
        check("rst_state", 32'(dbg_state), 0);
        reset = 1'b0;
        cycles(2);

        // Single request on line 2: latency and ack.
        bus.In_n[2] = 1'b0;
        cycles(10);
        check("t1_pend_e9", 32'(bus.pending), 0);
        cycles(1);
        check("t1_pend_e10", 32'(bus.pending), 32'h04);
        check("t1_valid_e10", 32'(bus.valid), 0);
        cycles(1);
        check("t1_valid_e11", 32'(bus.valid), 1);
        check("t1_S_e11", 32'(bus.S), 3);
        cycles(3);
        bus.ack = 1'b1;
        cycles(1);
        bus.ack = 1'b0;
        check("t1_S_ack", 32'(bus.S), 0);
        check("t1_valid_ack", 32'(bus.valid), 0);
        check("t1_pend_ack", 32'(bus.pending), 0);
        bus.In_n[2] = 1'b1;
        cycles(20);

        // Short glitch on line 4 is filtered.
        grant_q.delete();
        bus.In_n[4] = 1'b0;
        cycles(5);
        bus.In_n[4] = 1'b1;
        cycles(20);
        check("t2_pending", 32'(bus.pending), 0);
        check("t2_grants", 32'(grant_q.size()), 0);

        // Lines 0,3,6 together with ack held high.
        grant_q.delete();
        max_run = 0;
        bus.ack = 1'b1;
        bus.In_n = 7'b0110110;
        cycles(30);
        exp_q = '{3'd1, 3'd4, 3'd7};
        compare_grants("t3a_grant");
        check("t3a_one_cycle", 32'(max_run), 1);
        bus.ack = 1'b0;
        bus.In_n = 7'h7f;
        cycles(20);

        // Line 0 re-fires during the grant of line 3.
        grant_q.delete();
        bus.In_n = 7'b0110110;
        cycles(12);
        check("t3b_S0", 32'(bus.S), 1);
        bus.ack = 1'b1;
        cycles(1);
        bus.ack = 1'b0;
        cycles(3);
        check("t3b_S3", 32'(bus.S), 4);
        bus.In_n[0] = 1'b1;
        cycles(12);
        bus.In_n[0] = 1'b0;
        cycles(12);
        check("t3b_pend", 32'(bus.pending), 32'b1001001);
        check("t3b_S3_held", 32'(bus.S), 4);
        bus.ack = 1'b1;
        cycles(10);
        bus.ack = 1'b0;
`ifdef ENC7_ROUND_ROBIN_EN
        exp_q = '{3'd1, 3'd4, 3'd7, 3'd1};
`else
        exp_q = '{3'd1, 3'd4, 3'd1, 3'd7};
`endif
        compare_grants("t3b_grant");
        bus.In_n = 7'h7f;
        cycles(20);

        // Overrun on line 5 while line 1 is being granted.
        grant_q.delete();
        ovr_count = 0;
        bus.In_n[1] = 1'b0;
        cycles(12);
        check("t4_S1", 32'(bus.S), 2);
        bus.In_n[5] = 1'b0;
        cycles(12);
        check("t4_pend", 32'(bus.pending), 32'b0100010);
        bus.In_n[5] = 1'b1;
        cycles(12);
        bus.In_n[5] = 1'b0;
        cycles(12);
        check("t4_ovr_count", 32'(ovr_count), 1);
        bus.ack = 1'b1;
        cycles(8);
        bus.ack = 1'b0;
        exp_q = '{3'd2, 3'd6};
        compare_grants("t4_grant");
        bus.In_n = 7'h7f;
        cycles(20);

        // Reset in the middle of a grant, line 1 kept low.
        bus.In_n[1] = 1'b0;
        cycles(12);
        check("t5_S_pre", 32'(bus.S), 2);
        reset = 1'b1;
        cycles(1);
        check("t5_S_rst", 32'(bus.S), 0);
        check("t5_valid_rst", 32'(bus.valid), 0);
        check("t5_pend_rst", 32'(bus.pending), 0);
        reset = 1'b0;
        cycles(11);
        check("t5_valid_e10", 32'(bus.valid), 0);
        cycles(1);
        check("t5_valid_e11", 32'(bus.valid), 1);
        check("t5_S_e11", 32'(bus.S), 2);
        bus.ack = 1'b1;
        cycles(1);
        bus.ack = 1'b0;
        bus.In_n = 7'h7f;
        cycles(20);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 7; k++) begin
                if ($urandom_range(0, 19) == 0) bus.In_n[k] = ~bus.In_n[k];
            end
            bus.ack = ($urandom_range(0, 2) == 0);
            cycles(1);
        end
        bus.ack = 1'b0;
        bus.In_n = 7'h7f;
        cycles(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
